ram_reader: RTL and testbench
=============================

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the RAM word width; it is fixed at 2 bytes.
REQ-003 The block SHALL have parameter AUTO_DIV, default 50000000, meaning the auto-step period in clk cycles; it is used only with READER_AUTO_EN.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port next, input, 1 bit: step button, level, active-high.
REQ-007 The block SHALL have port load, input, 1 bit: load-address button, level, active-high.
REQ-008 The block SHALL have port startAddr, input, ADDR_W bits: start address from the switches.
REQ-009 The block SHALL have port rdData, input, DATA_W bits: RAM read data, valid one cycle after the RAM samples rdEn=1.
REQ-010 The block SHALL have port addrRd, output, ADDR_W bits: RAM read address, registered.
REQ-011 The block SHALL have port rdEn, output, 1 bit: RAM read strobe, registered.
REQ-012 The block SHALL have port led, output, 8 bits: displayed byte, registered.
REQ-013 The block SHALL have port hiSel, output, 1 bit: 1 when led shows word[15:8], registered.
REQ-014 The block SHALL have port busy, output, 1 bit: 1 while a read is in flight, registered.

Function
REQ-015 Button events SHALL be release edges: event = prev & ~cur, with prev registered each clk; one event per press regardless of hold length.
REQ-016 The FSM SHALL have states IDLE, FETCH, WAIT, SHOW_HI and SHOW_LO.
REQ-017 In IDLE, a load event SHALL set addrRd=startAddr and stay in IDLE; a next event SHALL go to FETCH.
REQ-018 In FETCH, rdEn SHALL be 1 for exactly one cycle, busy SHALL be 1, and the state SHALL go to WAIT.
REQ-019 In WAIT, busy SHALL be 1, rdData SHALL be latched into the word register, and the state SHALL go to SHOW_HI with led=rdData[15:8] and hiSel=1 on the same edge.
REQ-020 Latency SHALL be 3 clk cycles from the next-event cycle to led updated.
REQ-021 In SHOW_HI, a next event SHALL give led=word[7:0], hiSel=0, and go to SHOW_LO.
REQ-022 In SHOW_LO, a next event SHALL set addrRd=addrRd+1 modulo 2^ADDR_W (255 wraps to 0) and go to FETCH.
REQ-023 In SHOW_HI or SHOW_LO, a load event SHALL set addrRd=startAddr, led=0 and hiSel=0, and go to IDLE.
REQ-024 Simultaneous load and next events SHALL give load priority.
REQ-025 Events arriving in FETCH or WAIT SHALL be ignored and not queued.
REQ-026 rdEn SHALL never be 1 outside FETCH; addrRd SHALL be stable while rdEn=1.

Reset
REQ-027 rst=0 SHALL force, asynchronously: state=IDLE, addrRd=0, rdEn=0, led=0, hiSel=0, busy=0, word=0, and both edge-detector prev registers=0.
REQ-028 Reset asserted mid-FETCH or mid-WAIT SHALL abort the read; the first release after reset SHALL be treated as a fresh event.

Configuration
REQ-029 With macro READER_AUTO_EN defined, a free-running counter SHALL generate a step tick every AUTO_DIV cycles in SHOW_HI and SHOW_LO, acting as a next event.
REQ-030 The auto-step counter SHALL clear on every state change and on reset.
REQ-031 Without READER_AUTO_EN, no counter logic SHALL exist and only the next button SHALL step.

Structure
REQ-032 Package ram_reader_pkg SHALL hold the state encoding constants and the default ADDR_W, DATA_W and AUTO_DIV values.
REQ-033 Sub-module btn_edge (prev register plus release-edge output) SHALL be instantiated twice, for next and load.

Verification
REQ-034 Reset, then rst=1; release next with RAM[0]=16'hA55A -> rdEn pulses 1 cycle with addrRd=0; 3 cycles later led=8'hA5, hiSel=1.
REQ-035 Release next again -> led=8'h5A, hiSel=0; release next again -> addrRd=1 and rdEn pulses once.
REQ-036 With startAddr=8'hFF, release load then step through the word -> the next fetch uses addrRd=8'h00 (wrap).
REQ-037 Release load and next in the same cycle while in SHOW_LO -> IDLE, addrRd=startAddr, no rdEn pulse.
REQ-038 Press next during WAIT -> ignored, led shows the high byte, and exactly one rdEn pulse occurs in total.
REQ-039 Assert rst=0 during FETCH -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ram_reader_pkg.sv
// Shared types and defaults for the RAM byte reader: FSM state encoding and
// the default address width, word width and auto-step period.
package ram_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_SHOW_HI = 3'd3,
    S_SHOW_LO = 3'd4
  } state_e;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_AUTO_DIV = 50000000;

endpackage

// File: rtl/btn_edge.sv
// Release-edge detector for a level button: one event per press, on the
// cycle the button drops, however long it was held.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic prev_q;

  // NOTE: state is assigned with <= so every register samples the pre-edge
  // values; blocking here would make ordering between blocks matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= btn;
  end

  assign evt = prev_q & ~btn;

endmodule

// File: rtl/ram_reader.sv
// Steps through a synchronous RAM one word at a time, showing the high then
// the low byte on the LEDs. Define READER_AUTO_EN to add a timed auto-step.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int AUTO_DIV = DEF_AUTO_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next,
  input  logic              load,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [DATA_W-1:0] rdData,
  output logic [ADDR_W-1:0] addrRd,
  output logic              rdEn,
  output logic [7:0]        led,
  output logic              hiSel,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [7:0]          led_q, led_d;
  logic                hi_q, hi_d;
  logic                rden_q, rden_d;
  logic                busy_q, busy_d;
  logic                next_evt, load_evt, step;

  btn_edge u_next_edge (.clk(clk), .rst(rst), .btn(next), .evt(next_evt));
  btn_edge u_load_edge (.clk(clk), .rst(rst), .btn(load), .evt(load_evt));

`ifdef READER_AUTO_EN
  logic [31:0] auto_cnt_q, auto_cnt_d;
  logic        showing, auto_tick;

  assign showing   = (state_q == S_SHOW_HI) || (state_q == S_SHOW_LO);
  assign auto_tick = showing && (auto_cnt_q == 32'(AUTO_DIV - 1));
  assign step      = next_evt | auto_tick;

  // Restarts on any state change so each displayed byte gets a full period.
  always_comb begin
    if (state_d != state_q || !showing || auto_tick) auto_cnt_d = '0;
    else                                             auto_cnt_d = auto_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) auto_cnt_q <= '0;
    else      auto_cnt_q <= auto_cnt_d;
  end
`else
  assign step = next_evt;
`endif

  // NOTE: every next-state signal gets its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    led_d   = led_q;
    hi_d    = hi_q;
    unique case (state_q)
      S_IDLE: begin
        if (load_evt)  addr_d  = startAddr;
        else if (step) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        word_d  = rdData;
        led_d   = rdData[DATA_W-1 -: 8];
        hi_d    = 1'b1;
        state_d = S_SHOW_HI;
      end
      S_SHOW_HI, S_SHOW_LO: begin
        if (load_evt) begin
          addr_d  = startAddr;
          led_d   = 8'h00;
          hi_d    = 1'b0;
          state_d = S_IDLE;
        end else if (step) begin
          if (state_q == S_SHOW_HI) begin
            led_d   = word_q[7:0];
            hi_d    = 1'b0;
            state_d = S_SHOW_LO;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes are decoded from the next state so they line up with it.
    rden_d = (state_d == S_FETCH);
    busy_d = (state_d == S_FETCH) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      led_q   <= 8'h00;
      hi_q    <= 1'b0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      led_q   <= led_d;
      hi_q    <= hi_d;
      rden_q  <= rden_d;
      busy_q  <= busy_d;
    end
  end

  assign addrRd = addr_q;
  assign rdEn   = rden_q;
  assign led    = led_q;
  assign hiSel  = hi_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: a per-cycle vector table plus hand-written
// sequences for asynchronous reset mid-read and the first release after it.
module tb_ram_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        next;
  logic        load;
  logic [7:0]  startAddr;
  logic [15:0] rdData;
  logic [7:0]  addrRd;
  logic        rdEn;
  logic [7:0]  led;
  logic        hiSel;
  logic        busy;

  logic [15:0] mem [256];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       nxt;
    logic       ld;
    logic [7:0] sa;
    logic [7:0] e_addr;
    logic       e_rden;
    logic [7:0] e_led;
    logic       e_hi;
    logic       e_busy;
  } vec_t;

  vec_t vec [32];

  ram_reader dut (
    .clk(clk), .rst(rst), .next(next), .load(load), .startAddr(startAddr),
    .rdData(rdData), .addrRd(addrRd), .rdEn(rdEn), .led(led),
    .hiSel(hiSel), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data appears the cycle after it samples rdEn.
  always @(posedge clk) if (rdEn) rdData <= mem[addrRd];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] a, input logic r,
                            input logic [7:0] l, input logic h, input logic b);
    check({tag, ".addrRd"}, 32'(addrRd), 32'(a));
    check({tag, ".rdEn"},   32'(rdEn),   32'(r));
    check({tag, ".led"},    32'(led),    32'(l));
    check({tag, ".hiSel"},  32'(hiSel),  32'(h));
    check({tag, ".busy"},   32'(busy),   32'(b));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h00] = 16'hA55A;
    mem[8'h01] = 16'h1234;
    mem[8'h42] = 16'h7788;
    mem[8'hFF] = 16'hBEEF;

    // {next, load, startAddr, exp addrRd, exp rdEn, exp led, exp hiSel, exp busy}
    vec[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0}; // press, no event
    vec[1]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1}; // release -> FETCH
    vec[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1}; // WAIT
    vec[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0}; // SHOW_HI
    vec[4]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0}; // SHOW_LO
    vec[6]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 8'h5A, 1'b0, 1'b1}; // addr+1, FETCH
    vec[8]  = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h5A, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8'h12, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b1, 8'hFF, 8'h01, 1'b0, 8'h12, 1'b1, 1'b0}; // load pressed
    vec[11] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0}; // load -> IDLE
    vec[12] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[13] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};
    vec[14] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
    vec[15] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hBE, 1'b1, 1'b0};
    vec[16] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hBE, 1'b1, 1'b0};
    vec[17] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hEF, 1'b0, 1'b0};
    vec[18] = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'hEF, 1'b0, 1'b0};
    vec[19] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'hEF, 1'b0, 1'b1}; // wrap to 0
    vec[20] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hEF, 1'b0, 1'b1};
    vec[21] = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0};
    vec[22] = '{1'b1, 1'b0, 8'h42, 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0};
    vec[23] = '{1'b0, 1'b0, 8'h42, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0}; // SHOW_LO
    vec[24] = '{1'b1, 1'b1, 8'h42, 8'h00, 1'b0, 8'h5A, 1'b0, 1'b0}; // both pressed
    vec[25] = '{1'b0, 1'b0, 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0}; // load wins
    vec[26] = '{1'b0, 1'b0, 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0}; // still no rdEn
    vec[27] = '{1'b1, 1'b0, 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0};
    vec[28] = '{1'b0, 1'b0, 8'h42, 8'h42, 1'b1, 8'h00, 1'b0, 1'b1}; // FETCH
    vec[29] = '{1'b1, 1'b0, 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1}; // WAIT, pressing
    vec[30] = '{1'b0, 1'b0, 8'h42, 8'h42, 1'b0, 8'h77, 1'b1, 1'b0}; // release ignored
    vec[31] = '{1'b0, 1'b0, 8'h42, 8'h42, 1'b0, 8'h77, 1'b1, 1'b0}; // no second fetch

    rst = 1'b0; next = 1'b0; load = 1'b0; startAddr = 8'h00;
    #12;
    check_outs("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      next = vec[i].nxt; load = vec[i].ld; startAddr = vec[i].sa;
      @(posedge clk); #1;
      check_outs($sformatf("vec%0d", i), vec[i].e_addr, vec[i].e_rden,
                 vec[i].e_led, vec[i].e_hi, vec[i].e_busy);
    end

    // Async reset during FETCH: outputs clear before any clock edge.
    @(negedge clk) begin load = 1'b1; startAddr = 8'h01; end
    @(negedge clk) load = 1'b0;        // SHOW_HI -> IDLE, addr 01
    @(negedge clk) next = 1'b1;
    @(negedge clk) next = 1'b0;
    @(posedge clk); #1;
    check_outs("pre_abort", 8'h01, 1'b1, 8'h00, 1'b0, 1'b1);
    #2 rst = 1'b0;
    #1 check_outs("async_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Next held across reset release: its release is a fresh event.
    next = 1'b1;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_outs("held", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk) next = 1'b0;
    @(posedge clk); #1;
    check_outs("fresh_fetch", 8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outs("fresh_show", 8'h00, 1'b0, 8'hA5, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
